// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: front-end frame controller for a multi-channel streaming FFT core.
// Each frame issues one config word, waits CONFIG_LATENCY cycles, and then
// frames the input stream to exactly N = 2^nfft beats. Short records are
// zero-padded and long records are truncated, with the excess drained.
// The core output is passed straight through to the host stream.
//
// Optional feature macro: FFT_SCALING_EN. It adds scale_sch, which is
// replicated per channel into the config word and widens CFG_WIDTH.
//
// Ports:
//   aclk, aresetn             clock, async active-low reset
//   start/nfft_log2/fwd_inv   frame request, sampled in IDLE
//   s_axis_*                  sample stream in
//   fft_cfg_*                 config channel to the core
//   fft_s_*                   data channel to the core
//   fft_m_* / m_axis_*        core output, combinational pass-through
//   busy, frame_count, pad_count, truncated   status
module fft_frame_ctrl #(
  parameter int MAX_FFT_LEN    = 8192,
  parameter int FFT_CHANNELS   = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int CONFIG_LATENCY = 16,
  parameter int MIN_LOG2       = 3,
  localparam int LOG2_MAX      = $clog2(MAX_FFT_LEN),
`ifdef FFT_SCALING_EN
  localparam int SCH_W         = 2 * ((LOG2_MAX + 1) / 2),
  localparam int CFG_WIDTH     = ((8 + FFT_CHANNELS + FFT_CHANNELS * SCH_W + 7) / 8) * 8,
`else
  localparam int CFG_WIDTH     = 16,
`endif
  localparam int DW            = FFT_CHANNELS * DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [4:0]            nfft_log2,
  input  logic                  fwd_inv,
`ifdef FFT_SCALING_EN
  input  logic [SCH_W-1:0]      scale_sch,
`endif
  input  logic [DW-1:0]         s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [CFG_WIDTH-1:0]  fft_cfg_tdata,
  output logic                  fft_cfg_tvalid,
  input  logic                  fft_cfg_tready,
  output logic [DW-1:0]         fft_s_tdata,
  output logic                  fft_s_tvalid,
  output logic                  fft_s_tlast,
  input  logic                  fft_s_tready,
  input  logic [DW-1:0]         fft_m_tdata,
  input  logic                  fft_m_tvalid,
  input  logic                  fft_m_tlast,
  output logic                  fft_m_tready,
  output logic [DW-1:0]         m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic [LOG2_MAX:0]     pad_count,
  output logic                  truncated
);

  localparam int CW = LOG2_MAX + 1;
  localparam int LW = $clog2(CONFIG_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CONFIG, CFG_WAIT, WR_DATA, ZP_DATA, DRAIN, RD_DATA} state_t;

  state_t          state, state_nxt;
  logic [4:0]      nfft, nfft_clamped;
  logic            fwd;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   n_last;
  logic [LW-1:0]   wait_cnt;
  logic            last_beat;
  logic            core_beat;
  logic [CFG_WIDTH-1:0] cfg_word;
`ifdef FFT_SCALING_EN
  logic [SCH_W-1:0] sch;
`endif

  // core output path never depends on the frame state
  assign m_axis_tdata  = fft_m_tdata;
  assign m_axis_tvalid = fft_m_tvalid;
  assign m_axis_tlast  = fft_m_tlast;
  assign fft_m_tready  = m_axis_tready;

  assign busy      = (state != IDLE);
  assign n_last    = CW'((1 << nfft) - 1);
  assign last_beat = (beat_cnt == n_last);
  assign core_beat = fft_s_tvalid & fft_s_tready;

  always_comb begin
    nfft_clamped = nfft_log2;
    if (nfft_log2 < 5'(MIN_LOG2))      nfft_clamped = 5'(MIN_LOG2);
    else if (nfft_log2 > 5'(LOG2_MAX)) nfft_clamped = 5'(LOG2_MAX);
  end

  // config word is built from latched values, so it is stable while CONFIG waits
  always_comb begin
    cfg_word      = '0;
    cfg_word[4:0] = nfft;
    for (int c = 0; c < FFT_CHANNELS; c++) begin
      cfg_word[8 + c] = fwd;
`ifdef FFT_SCALING_EN
      cfg_word[8 + FFT_CHANNELS + c * SCH_W +: SCH_W] = sch;
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      nfft        <= '0;
      fwd         <= 1'b0;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      frame_count <= '0;
      pad_count   <= '0;
      truncated   <= 1'b0;
`ifdef FFT_SCALING_EN
      sch         <= '0;
`endif
    end else begin
      state     <= state_nxt;
      truncated <= (state == DRAIN) && s_axis_tvalid && s_axis_tlast;
      if (state == IDLE && start) begin
        nfft      <= nfft_clamped;
        fwd       <= fwd_inv;
        beat_cnt  <= '0;
        pad_count <= '0;
`ifdef FFT_SCALING_EN
        sch       <= scale_sch;
`endif
      end
      if (state == CONFIG)        wait_cnt <= '0;
      else if (state == CFG_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (core_beat) beat_cnt <= beat_cnt + 1'b1;
      if (state == ZP_DATA && core_beat) pad_count <= pad_count + 1'b1;
      if (state == RD_DATA && fft_m_tvalid && m_axis_tready && fft_m_tlast)
        frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    s_axis_tready  = 1'b0;
    fft_s_tvalid   = 1'b0;
    fft_s_tdata    = '0;
    fft_s_tlast    = 1'b0;
    fft_cfg_tvalid = 1'b0;
    fft_cfg_tdata  = '0;
    case (state)
      IDLE:     if (start) state_nxt = CONFIG;
      CONFIG: begin
        fft_cfg_tvalid = 1'b1;
        fft_cfg_tdata  = cfg_word;
        if (fft_cfg_tready) state_nxt = CFG_WAIT;
      end
      CFG_WAIT: if (wait_cnt == LW'(CONFIG_LATENCY - 1)) state_nxt = WR_DATA;
      WR_DATA: begin
        s_axis_tready = fft_s_tready;
        fft_s_tvalid  = s_axis_tvalid;
        fft_s_tdata   = s_axis_tdata;
        fft_s_tlast   = last_beat;
        if (s_axis_tvalid && fft_s_tready) begin
          if (last_beat)         state_nxt = s_axis_tlast ? RD_DATA : DRAIN;
          else if (s_axis_tlast) state_nxt = ZP_DATA;
        end
      end
      ZP_DATA: begin
        fft_s_tvalid = 1'b1;
        fft_s_tlast  = last_beat;
        if (fft_s_tready && last_beat) state_nxt = RD_DATA;
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = RD_DATA;
      end
      RD_DATA:  if (fft_m_tvalid && m_axis_tready && fft_m_tlast) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl. A frame-level model predicts the
// beats the core must see (record prefix, zero fill, single tlast at N-1),
// pad count, truncation pulses and frame count.
module tb_fft_frame_ctrl;
  localparam int CH = 2, DWC = 32, DW = CH * DWC, LAT = 16, TMO = 40000;
  localparam int DEPTH = 32768;
`ifdef FFT_SCALING_EN
  localparam int SCH_W = 14, CFG_W = 40;
`else
  localparam int CFG_W = 16;
`endif

  logic aclk = 1'b0, aresetn = 1'b0, start = 1'b0, fwd_inv = 1'b0;
  logic [4:0] nfft_log2 = '0;
`ifdef FFT_SCALING_EN
  logic [SCH_W-1:0] scale_sch = '0;
`endif
  logic [DW-1:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic [CFG_W-1:0] fft_cfg_tdata;
  logic fft_cfg_tvalid, fft_cfg_tready = 1'b0;
  logic [DW-1:0] fft_s_tdata;
  logic fft_s_tvalid, fft_s_tlast, fft_s_tready = 1'b1;
  logic [DW-1:0] fft_m_tdata = '0;
  logic fft_m_tvalid = 1'b0, fft_m_tlast = 1'b0, fft_m_tready;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
  logic busy, truncated;
  logic [15:0] frame_count;
  logic [13:0] pad_count;

  fft_frame_ctrl #(.MAX_FFT_LEN(8192), .FFT_CHANNELS(CH), .DATA_WIDTH(DWC),
                   .CONFIG_LATENCY(LAT), .MIN_LOG2(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .nfft_log2(nfft_log2), .fwd_inv(fwd_inv),
`ifdef FFT_SCALING_EN
    .scale_sch(scale_sch),
`endif
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tready(fft_cfg_tready),
    .fft_s_tdata(fft_s_tdata), .fft_s_tvalid(fft_s_tvalid), .fft_s_tlast(fft_s_tlast),
    .fft_s_tready(fft_s_tready),
    .fft_m_tdata(fft_m_tdata), .fft_m_tvalid(fft_m_tvalid), .fft_m_tlast(fft_m_tlast),
    .fft_m_tready(fft_m_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy(busy), .frame_count(frame_count), .pad_count(pad_count), .truncated(truncated)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // core data-ready pattern: 0 = always ready, 1 = random, 2 = alternate
  int rdy_mode = 0;
  always begin
    @(posedge aclk); #1;
    case (rdy_mode)
      1:       fft_s_tready = 1'($urandom);
      2:       fft_s_tready = ~fft_s_tready;
      default: fft_s_tready = 1'b1;
    endcase
  end

  // observed traffic, indexed by running counters so the stimulus only snapshots them
  logic [DW-1:0] out_data [0:DEPTH-1];
  logic          out_last [0:DEPTH-1];
  int out_n = 0, in_acc = 0, trunc_n = 0;
  always @(negedge aclk) if (aresetn) begin
    if (fft_s_tvalid && fft_s_tready) begin
      out_data[out_n % DEPTH] <= fft_s_tdata;
      out_last[out_n % DEPTH] <= fft_s_tlast;
      out_n <= out_n + 1;
    end
    if (s_axis_tvalid && s_axis_tready) in_acc <= in_acc + 1;
    if (truncated) trunc_n <= trunc_n + 1;
  end

  logic [DW-1:0] in_data [0:8191];
  int fc_exp = 0;

  function automatic int clampn(input int v);
    return (v < 3) ? 3 : ((v > 13) ? 13 : v);
  endfunction

  task automatic run_frame(input int nl, input bit fw, input int len, input int rmode,
                           input int hold, input bit rst_mid);
    int n, nb, bo, bi, bt, t, bad, lasts, lastpos;
    logic [CFG_W-1:0] cw;
    logic [DW-1:0] ev, md;
`ifdef FFT_SCALING_EN
    logic [SCH_W-1:0] sv;
`endif
    n = clampn(nl); nb = 1 << n;
    cw = '0; cw[4:0] = 5'(n);
    for (int c = 0; c < CH; c++) cw[8 + c] = fw;
    bo = out_n; bi = in_acc; bt = trunc_n;
    rdy_mode = 0;
    @(posedge aclk); #1;
    start = 1'b1; nfft_log2 = 5'(nl); fwd_inv = fw;
`ifdef FFT_SCALING_EN
    sv = SCH_W'($urandom); scale_sch = sv;
    for (int c = 0; c < CH; c++) cw[8 + CH + c * SCH_W +: SCH_W] = sv;
`endif
    @(posedge aclk); #1;
    start = 1'b0; nfft_log2 = 5'($urandom); fwd_inv = 1'($urandom);
    @(negedge aclk);
    chk("cfg_vld", fft_cfg_tvalid, 1); chk("cfg_word", fft_cfg_tdata, cw);
    repeat (hold) @(negedge aclk);
    chk("cfg_hold_vld", fft_cfg_tvalid, 1); chk("cfg_hold_word", fft_cfg_tdata, cw);
    fft_cfg_tready = 1'b1;
    @(posedge aclk); #1 fft_cfg_tready = 1'b0;
    t = 0; @(negedge aclk);
    while (!s_axis_tready && t < 200) begin t++; @(negedge aclk); end
    chk("cfg_latency", t, LAT);
    @(posedge aclk); #1 rdy_mode = rmode;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(3) == 0) begin s_axis_tvalid = 1'b0; @(posedge aclk); #1; end
      ev = {$urandom, $urandom};
      if (i < 8192) in_data[i] = ev;
      s_axis_tdata = ev; s_axis_tvalid = 1'b1; s_axis_tlast = (i == len - 1);
      t = 0; @(negedge aclk);
      while (!s_axis_tready && t < TMO) begin t++; @(negedge aclk); end
      if (t >= TMO) begin chk("in_timeout", t, 0); break; end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (rst_mid) begin
      t = 0;
      while (out_n - bo < 8 && t < TMO) begin @(negedge aclk); t++; end
      #2 aresetn = 1'b0; #1;
      chk("rst_busy", busy, 0); chk("rst_svld", fft_s_tvalid, 0);
      chk("rst_cvld", fft_cfg_tvalid, 0); chk("rst_srdy", s_axis_tready, 0);
      chk("rst_fc", frame_count, fc_exp); chk("rst_pad", pad_count, 0);
      @(posedge aclk); #1 aresetn = 1'b1;
      rdy_mode = 0;
      return;
    end
    t = 0;
    while (!((out_n - bo) >= nb && (in_acc - bi) >= len) && t < TMO) begin @(negedge aclk); t++; end
    chk("done_timeout", t < TMO, 1);
    repeat (2) @(negedge aclk);
    chk("beats", out_n - bo, nb);
    chk("in_acc", in_acc - bi, len);
    bad = 0; lasts = 0; lastpos = -1;
    for (int i = 0; i < nb; i++) begin
      ev = (i < len) ? in_data[i] : '0;
      if (out_data[(bo + i) % DEPTH] !== ev) bad++;
      if (out_last[(bo + i) % DEPTH]) begin lasts++; lastpos = i; end
    end
    chk("data_bad", bad, 0); chk("tlast_cnt", lasts, 1); chk("tlast_pos", lastpos, nb - 1);
    chk("pad", pad_count, (len < nb) ? nb - len : 0);
    chk("trunc", trunc_n - bt, (len > nb) ? 1 : 0);
    chk("busy_rd", busy, 1);
    rdy_mode = 0;
    // a start while busy must not reopen the config phase
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
    @(negedge aclk); chk("start_ign", fft_cfg_tvalid, 0);
    // core output stalled by the host: tlast present but not accepted
    @(posedge aclk); #1;
    md = {$urandom, $urandom};
    fft_m_tdata = md; fft_m_tvalid = 1'b1; fft_m_tlast = 1'b1; m_axis_tready = 1'b0;
    @(negedge aclk);
    chk("m_rdy_lo", fft_m_tready, 0); chk("m_data", m_axis_tdata, md);
    chk("m_vld", m_axis_tvalid, 1); chk("m_last", m_axis_tlast, 1);
    repeat (3) @(negedge aclk);
    chk("fc_stall", frame_count, fc_exp);
    @(posedge aclk); #1 m_axis_tready = 1'b1;
    @(negedge aclk); chk("m_rdy_hi", fft_m_tready, 1);
    @(posedge aclk); #1 fft_m_tvalid = 1'b0; fft_m_tlast = 1'b0; m_axis_tready = 1'b0;
    fc_exp = (fc_exp + 1) & 16'hFFFF;
    @(negedge aclk);
    chk("frame_count", frame_count, fc_exp); chk("idle", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nl, n, len;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy0", busy, 0); chk("rst_fc0", frame_count, 0); chk("rst_pad0", pad_count, 0);
    chk("rst_cfg0", fft_cfg_tvalid, 0); chk("rst_cdat0", fft_cfg_tdata, 0);
    chk("rst_srdy0", s_axis_tready, 0); chk("rst_svld0", fft_s_tvalid, 0);
    chk("rst_trunc0", truncated, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    run_frame(4, 1'b0, 5, 0, 0, 1'b1);      // reset in the middle of zero padding
    run_frame(4, 1'b1, 10, 0, 5, 1'b0);     // config hold + zero pad
    run_frame(4, 1'b0, 20, 1, 0, 1'b0);     // truncate
    run_frame(4, 1'b1, 16, 2, 2, 1'b0);     // exact length, alternating ready
    run_frame(20, 1'b1, 8192, 0, 1, 1'b0);  // clamp high
    run_frame(1, 1'b0, 6, 1, 0, 1'b0);      // clamp low
    for (int k = 0; k < 8; k++) begin
      nl = $urandom_range(0, 8); n = clampn(nl);
      len = $urandom_range(1, (3 << n) / 2);
      run_frame(nl, 1'($urandom), len, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
